// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the round-robin L2 memory arbiter.
package mem_arbiter_rr_pkg;

    localparam int unsigned LC3B_WORD_W = 16;
    localparam int unsigned LC3B_LINE_W = 128;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_cache_line;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Rotating-priority picker: first pending port at or after ptr, wrapping modulo N.
module rr_priority_picker #(
    parameter  int unsigned N  = 2,
    localparam int unsigned GW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [GW-1:0] ptr,
    output logic          valid,
    output logic [GW-1:0] idx
);

    logic [GW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = GW'((32'(ptr) + k) % N);
            if (!valid && pending[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter onto a single L2 port: one whole line transaction at a time,
// command latched at grant, completion routed back to the granted port only.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 2,
    parameter  int unsigned ADDR_WIDTH = LC3B_WORD_W,
    parameter  int unsigned LINE_WIDTH = LC3B_LINE_W,
    localparam int unsigned GW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_resp,
    output logic [ADDR_WIDTH-1:0]         l2_mem_address,
    output logic                          l2_mem_read,
    output logic                          l2_mem_write,
    output logic [LINE_WIDTH-1:0]         l2_mem_wdata,
    input  logic [LINE_WIDTH-1:0]         l2_mem_rdata,
    input  logic                          l2_mem_resp,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id
);

    arb_state_t            state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    pending;
    logic                  pick_valid;
    logic [GW-1:0]         pick_idx;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [LINE_WIDTH-1:0] wdata_arr [NUM_REQ];

    // Unpack the flat per-port buses so the winner can be selected by index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
    end

    assign pending = req_read | req_write;

    rr_priority_picker #(
        .N(NUM_REQ)
    ) u_picker (
        .pending(pending),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Next-state, command latch and completion decode.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        busy_d   = busy_q;
        req_resp = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    rd_d    = req_read[pick_idx];
                    wr_d    = req_write[pick_idx];
                    busy_d  = 1'b1;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (l2_mem_resp) begin
                    req_resp = NUM_REQ'(1) << grant_q;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    busy_d   = 1'b0;
                    ptr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
        end
    end

    assign req_rdata      = l2_mem_rdata;
    assign l2_mem_address = addr_q;
    assign l2_mem_read    = rd_q;
    assign l2_mem_write   = wr_q;
    assign l2_mem_wdata   = wdata_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr (4 ports): transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random L2 latency.
module tb_mem_arbiter_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 128;
    localparam int unsigned GW = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]  req_read;
    logic [N-1:0]  req_write;
    logic [N*LW-1:0] req_wdata;
    logic [LW-1:0] req_rdata;
    logic [N-1:0]  req_resp;
    logic [AW-1:0] l2_mem_address;
    logic          l2_mem_read;
    logic          l2_mem_write;
    logic [LW-1:0] l2_mem_wdata;
    logic [LW-1:0] l2_mem_rdata;
    logic          l2_mem_resp;
    logic          busy;
    logic [GW-1:0] grant_id;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;
    bit auto_l2  = 1'b0;
    int resp_cnt [N];

    // Reference model: one outstanding transaction, rotating priority pointer.
    bit            m_busy  = 1'b0;
    int            m_ptr   = 0;
    int            m_grant = 0;
    int            m_done  = -1;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    bit            m_rd    = 1'b0;
    bit            m_wr    = 1'b0;
    bit            m_found;
    int            m_p;
    logic [N-1:0]  exp_resp;

    int            g;
    bit            rw;
    int            rr;

    mem_arbiter_rr #(
        .NUM_REQ   (N),
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_address   (req_address),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_wdata     (req_wdata),
        .req_rdata     (req_rdata),
        .req_resp      (req_resp),
        .l2_mem_address(l2_mem_address),
        .l2_mem_read   (l2_mem_read),
        .l2_mem_write  (l2_mem_write),
        .l2_mem_wdata  (l2_mem_wdata),
        .l2_mem_rdata  (l2_mem_rdata),
        .l2_mem_resp   (l2_mem_resp),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] d);
        req_read[p]            = rd;
        req_write[p]           = wr;
        req_address[p*AW +: AW] = a;
        req_wdata[p*LW +: LW]   = d;
    endtask

    task automatic clear_reqs();
        req_read  = '0;
        req_write = '0;
    endtask

    // Wait (bounded) for a grant, hold it lat cycles, then complete it.
    task automatic serve(input int lat, output int gid);
        int w;
        w = 0;
        while (busy !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (busy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL serve_timeout: busy=%b required 1 at t=%0t", busy, $time);
            gid = -1;
            return;
        end
        gid = int'(grant_id);
        repeat (lat) tick();
        l2_mem_resp  = 1'b1;
        l2_mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        l2_mem_resp = 1'b0;
    endtask

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        m_done = -1;
        if (rst) begin
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_grant = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
        end else if (!m_busy) begin
            m_found = 1'b0;
            for (int k = 0; k < N; k++) begin
                m_p = (m_ptr + k) % N;
                if (!m_found && (req_read[m_p] || req_write[m_p])) begin
                    m_found = 1'b1;
                    m_busy  = 1'b1;
                    m_grant = m_p;
                    m_addr  = req_address[m_p*AW +: AW];
                    m_wdata = req_wdata[m_p*LW +: LW];
                    m_rd    = req_read[m_p];
                    m_wr    = req_write[m_p];
                end
            end
        end else if (l2_mem_resp) begin
            m_done  = m_grant;
            m_busy  = 1'b0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
            m_ptr   = (m_grant + 1) % N;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            exp_resp = (m_busy && l2_mem_resp === 1'b1) ? (N'(1) << m_grant) : '0;
            chk("busy",     LW'(busy),           LW'(m_busy));
            chk("grant_id", LW'(grant_id),       LW'(m_grant));
            chk("l2_read",  LW'(l2_mem_read),    LW'(m_rd));
            chk("l2_write", LW'(l2_mem_write),   LW'(m_wr));
            chk("l2_addr",  LW'(l2_mem_address), LW'(m_addr));
            chk("l2_wdata", l2_mem_wdata,        m_wdata);
            chk("req_resp", LW'(req_resp),       LW'(exp_resp));
            chk("req_rdata", req_rdata,          l2_mem_rdata);
            for (int p = 0; p < N; p++) if (req_resp[p] === 1'b1) resp_cnt[p]++;
            if (l2_mem_read === 1'b1 && l2_mem_write === 1'b1 && busy === 1'b1)
                $display("note: port %0d has read and write asserted together (illegal request)", grant_id);
        end
    end

    // Random L2 responder: random latency while busy, occasional stray pulse while idle.
    always @(posedge clk) begin
        #1;
        if (auto_l2) begin
            l2_mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (l2_mem_resp)  l2_mem_resp = 1'b0;
            else if (m_busy)  l2_mem_resp = ($urandom_range(0, 2) == 0);
            else              l2_mem_resp = ($urandom_range(0, 9) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        req_address  = '0;
        req_read     = '0;
        req_write    = '0;
        req_wdata    = '0;
        l2_mem_resp  = 1'b0;
        l2_mem_rdata = '0;
        for (int p = 0; p < N; p++) resp_cnt[p] = 0;
        tick();
        started = 1'b1;
        rst     = 1'b0;

        // Reset state
        chk("rst_busy",  LW'(busy),           LW'(0));
        chk("rst_grant", LW'(grant_id),       LW'(0));
        chk("rst_read",  LW'(l2_mem_read),    LW'(0));
        chk("rst_write", LW'(l2_mem_write),   LW'(0));
        chk("rst_addr",  LW'(l2_mem_address), LW'(0));
        chk("rst_wdata", l2_mem_wdata,        LW'(0));
        chk("rst_resp",  LW'(req_resp),       LW'(0));

        // Single read on port 1
        do_reset();
        set_req(1, 1'b1, 1'b0, 16'h1230, '0);
        chk("t1_read_pre", LW'(l2_mem_read), LW'(0));
        tick();
        chk("t1_read",  LW'(l2_mem_read),    LW'(1));
        chk("t1_addr",  LW'(l2_mem_address), LW'(16'h1230));
        chk("t1_grant", LW'(grant_id),       LW'(1));
        chk("t1_busy",  LW'(busy),           LW'(1));
        tick();
        chk("t1_resp_wait", LW'(req_resp), LW'(0));
        l2_mem_rdata = {16{8'hA5}};
        l2_mem_resp  = 1'b1;
        #1;
        chk("t1_resp",  LW'(req_resp), LW'(4'b0010));
        chk("t1_rdata", req_rdata,     {16{8'hA5}});
        tick();
        l2_mem_resp = 1'b0;
        req_read[1] = 1'b0;
        chk("t1_busy_after", LW'(busy),        LW'(0));
        chk("t1_read_after", LW'(l2_mem_read), LW'(0));

        // Contention between ports 0 and 1, both held continuously
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0100, '0);
        set_req(1, 1'b1, 1'b0, 16'h0200, '0);
        for (int i = 0; i < 4; i++) begin
            serve(i % 3, g);
            chk("t2_grant", LW'(g), LW'(i % 2));
        end
        clear_reqs();
        tick();

        // All four ports pending for eight transactions
        do_reset();
        for (int p = 0; p < N; p++) begin
            resp_cnt[p] = 0;
            set_req(p, 1'b1, 1'b0, AW'(16'h1000 + p), '0);
        end
        for (int i = 0; i < 8; i++) begin
            serve(1, g);
            chk("t3_grant", LW'(g), LW'(i % 4));
        end
        clear_reqs();
        tick();
        for (int p = 0; p < N; p++) chk("t3_resp_count", LW'(resp_cnt[p]), LW'(2));

        // Write on port 0 with wdata/address changed mid-transaction
        do_reset();
        set_req(0, 1'b0, 1'b1, 16'h0040, {4{32'hDEADBEEF}});
        tick();
        chk("t4_write", LW'(l2_mem_write),   LW'(1));
        chk("t4_read",  LW'(l2_mem_read),    LW'(0));
        chk("t4_addr",  LW'(l2_mem_address), LW'(16'h0040));
        chk("t4_wdata", l2_mem_wdata,        {4{32'hDEADBEEF}});
        req_wdata[0 +: LW]  = {4{32'h01234567}};
        req_address[0 +: AW] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wdata_hold", l2_mem_wdata,        {4{32'hDEADBEEF}});
            chk("t4_addr_hold",  LW'(l2_mem_address), LW'(16'h0040));
            chk("t4_write_hold", LW'(l2_mem_write),   LW'(1));
            chk("t4_read_hold",  LW'(l2_mem_read),    LW'(0));
        end
        l2_mem_resp = 1'b1;
        #1;
        chk("t4_resp", LW'(req_resp), LW'(4'b0001));
        tick();
        l2_mem_resp = 1'b0;
        clear_reqs();
        chk("t4_write_done", LW'(l2_mem_write), LW'(0));

        // Reset in the middle of a transaction
        do_reset();
        set_req(1, 1'b1, 1'b0, 16'h2222, '0);
        serve(0, g);
        chk("t5_first", LW'(g), LW'(1));
        clear_reqs();
        set_req(3, 1'b1, 1'b0, 16'h3333, '0);
        tick();
        chk("t5_busy",  LW'(busy),     LW'(1));
        chk("t5_grant", LW'(grant_id), LW'(3));
        rst         = 1'b1;
        req_read[3] = 1'b0;
        tick();
        rst = 1'b0;
        chk("t5_read_abort",  LW'(l2_mem_read),  LW'(0));
        chk("t5_write_abort", LW'(l2_mem_write), LW'(0));
        chk("t5_busy_abort",  LW'(busy),         LW'(0));
        chk("t5_grant_abort", LW'(grant_id),     LW'(0));
        l2_mem_resp = 1'b1;
        #1;
        chk("t5_late_resp", LW'(req_resp), LW'(0));
        tick();
        l2_mem_resp = 1'b0;
        chk("t5_idle", LW'(busy), LW'(0));
        set_req(0, 1'b1, 1'b0, 16'h0A0A, '0);
        set_req(3, 1'b1, 1'b0, 16'h3A3A, '0);
        serve(0, g);
        chk("t5_ptr_reset", LW'(g), LW'(0));
        clear_reqs();
        tick();

        // Idle with stray L2 responses
        do_reset();
        for (int i = 0; i < 20; i++) begin
            l2_mem_resp = ($urandom_range(0, 2) == 0);
            #1;
            chk("t6_resp", LW'(req_resp), LW'(0));
            tick();
            chk("t6_read",  LW'(l2_mem_read),  LW'(0));
            chk("t6_write", LW'(l2_mem_write), LW'(0));
            chk("t6_busy",  LW'(busy),         LW'(0));
        end
        l2_mem_resp = 1'b0;

        // Read and write together on one port: both strobes forwarded
        set_req(2, 1'b1, 1'b1, 16'h4444, {4{32'h5A5A5A5A}});
        tick();
        chk("t7_read",  LW'(l2_mem_read),  LW'(1));
        chk("t7_write", LW'(l2_mem_write), LW'(1));
        chk("t7_grant", LW'(grant_id),     LW'(2));
        serve(0, g);
        clear_reqs();
        tick();

        // Randomized traffic
        auto_l2 = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (m_done >= 0) begin
                req_read[m_done]  = 1'b0;
                req_write[m_done] = 1'b0;
            end
            rst = ($urandom_range(0, 249) == 0);
            for (int p = 0; p < N; p++) begin
                if (!(req_read[p] || req_write[p])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rw = 1'($urandom_range(0, 1));
                        set_req(p, !rw, rw, AW'($urandom()),
                                {$urandom(), $urandom(), $urandom(), $urandom()});
                    end
                end else begin
                    rr = int'($urandom_range(0, 31));
                    if (rr == 0) begin
                        req_read[p]  = 1'b0;
                        req_write[p] = 1'b0;
                    end else if (rr < 4) begin
                        req_address[p*AW +: AW] = AW'($urandom());
                        req_wdata[p*LW +: LW]   = {$urandom(), $urandom(), $urandom(), $urandom()};
                    end
                end
            end
        end
        auto_l2 = 1'b0;
        rst     = 1'b0;
        clear_reqs();
        tick();
        tick();
        l2_mem_resp = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
